// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: widths, round count, S-box table, layer functions, FSM state type.
// Latency: n/a (constants and pure combinational functions).
// Backpressure: n/a.
package present_pkg;

    localparam int KEY_SIZE   = 80;
    localparam int BLOCK_SIZE = 64;
    localparam int NUM_ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } enc_state_t;

    // 16 nibble S-boxes in parallel.
    function automatic logic [BLOCK_SIZE-1:0] s_layer(input logic [BLOCK_SIZE-1:0] x);
        logic [BLOCK_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = SBOX[x[4*i +: 4]];
        end
        return r;
    endfunction

    // Bit permutation: bit j lands at (16*j) mod 63; bit 63 is a fixed point.
    function automatic logic [BLOCK_SIZE-1:0] p_layer(input logic [BLOCK_SIZE-1:0] x);
        logic [BLOCK_SIZE-1:0] r;
        r = '0;
        for (int j = 0; j < 63; j++) begin
            r[(16*j) % 63] = x[j];
        end
        r[63] = x[63];
        return r;
    endfunction

endpackage

// File: rtl/present_enc_core_if.sv
// Host/sink bundle for the PRESENT engine: plaintext+key request channel and ciphertext result channel.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both channels; master drives requests and accepts results.
interface present_enc_core_if;
    import present_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCK_SIZE-1:0] plaintext;
    logic [KEY_SIZE-1:0]   key;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCK_SIZE-1:0] ciphertext;
    logic                  busy;

    // Host / sink side.
    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    // Engine side.
    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/present_key_step.sv
// PRESENT-80 key schedule step: rotate left 61, S-box top nibble, XOR round index into bits 19:15.
// Latency: combinational.
// Backpressure: none.
// Ports: key_in (80) current round key register, round (5) 1-based round index, key_out (80) next key.
module present_key_step
    import present_pkg::*;
(
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic [4:0]          round,
    output logic [KEY_SIZE-1:0] key_out
);

    always_comb begin
        key_out          = {key_in[18:0], key_in[79:19]};
        key_out[79:76]   = SBOX[key_out[79:76]];
        key_out[19:15]   = key_out[19:15] ^ round;
    end

endmodule

// File: rtl/present_enc_core.sv
// Iterative PRESENT-80 encryptor, one round per clk, one block in flight.
// Latency: out_valid rises 31 clk edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
// Ports: clk, rst (async active-high), bus (slave: in_valid/in_ready/plaintext/key,
//        out_valid/out_ready/ciphertext, busy = ROUND or DONE).
module present_enc_core
    import present_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    present_enc_core_if.slave   bus
);

    enc_state_t            state;
    enc_state_t            next_state;
    logic [4:0]            round;
    logic [BLOCK_SIZE-1:0] state_reg;
    logic [KEY_SIZE-1:0]   key_reg;
    logic [KEY_SIZE-1:0]   key_next;
    logic [BLOCK_SIZE-1:0] round_out;
    logic [BLOCK_SIZE-1:0] ct_reg;
    logic                  out_valid_reg;

    logic accept;
    logic last_round;
    logic release_out;

    present_key_step u_key_step (
        .key_in  (key_reg),
        .round   (round),
        .key_out (key_next)
    );

    assign round_out = p_layer(s_layer(state_reg ^ key_reg[79:16]));

    // in_ready is gated by rst so the host never sees a ready engine while it is held in reset.
    assign bus.in_ready   = (state == IDLE) && !rst;
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = out_valid_reg;
    assign bus.ciphertext = ct_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        last_round  = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = ROUND;
                end
            end
            ROUND: begin
                // Exact compare on the 5-bit counter; it stops at 31 rather than wrapping.
                if (round == 5'(NUM_ROUNDS)) begin
                    last_round = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round         <= 5'd0;
            state_reg     <= '0;
            key_reg       <= '0;
            ct_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                state_reg <= bus.plaintext;
                key_reg   <= bus.key;
                round     <= 5'd1;
            end
            if (state == ROUND) begin
                state_reg <= round_out;
                key_reg   <= key_next;
                if (!last_round) begin
                    round <= round + 5'd1;
                end
            end
            // key_next at round 31 is K32, the final whitening key.
            if (last_round) begin
                ct_reg        <= round_out ^ key_next[79:16];
                out_valid_reg <= 1'b1;
            end
            if (release_out) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_present_enc_core.sv
// Directed bench for present_enc_core: known-answer vectors, latency, hold in DONE,
// input disturbance during rounds, async reset abort; expected ciphertexts go through a scoreboard queue.
module tb_present_enc_core;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [63:0] sb[$];

    present_enc_core_if bus ();

    present_enc_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp,
                             input bit disturb, input int hold);
        int          n;
        logic [63:0] want;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 80'(bus.in_ready), 80'd1);
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_round", 80'(bus.busy), 80'd1);
        check("in_ready_round", 80'(bus.in_ready), 80'd0);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            if (disturb) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
                bus.plaintext = {$urandom(), $urandom()};
                bus.key       = {$urandom(), $urandom(), 16'($urandom())};
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("latency", 80'(n), 80'd31);
        if (sb.size() > 0) want = sb.pop_front();
        else want = 'x;
        check("ciphertext", 80'(bus.ciphertext), 80'(want));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 80'(bus.out_valid), 80'd1);
            check("hold_ct", 80'(bus.ciphertext), 80'(want));
            check("hold_in_ready", 80'(bus.in_ready), 80'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_out_valid", 80'(bus.out_valid), 80'd0);
        check("release_in_ready", 80'(bus.in_ready), 80'd1);
        check("release_busy", 80'(bus.busy), 80'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 80'(bus.in_ready), 80'd0);
        check("rst_out_valid", 80'(bus.out_valid), 80'd0);
        check("rst_ct", 80'(bus.ciphertext), 80'd0);
        check("rst_busy", 80'(bus.busy), 80'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 80'(bus.in_ready), 80'd1);

        // Stray out_ready while nothing is pending.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_ready", 80'(bus.out_valid), 80'd0);

        // Known-answer vectors; first one held 10 cycles in DONE.
        run_block(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0, 10);
        run_block(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, 0);
        run_block({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0, 0);
        run_block({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, 2);

        // Inputs churn during ROUND; result must still be vector 1.
        run_block(64'h0, 80'h0, 64'h5579C1387B228445, 1'b1, 1);

        // Abort around round 12 with async reset.
        bus.plaintext = 64'h0123456789ABCDEF;
        bus.key       = 80'h0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 80'(bus.out_valid), 80'd0);
        check("abort_ct", 80'(bus.ciphertext), 80'd0);
        check("abort_busy", 80'(bus.busy), 80'd0);
        check("abort_in_ready", 80'(bus.in_ready), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_block(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, 0);

        check("scoreboard_empty", 80'(sb.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
